// File: rtl/step_move_gate.sv
// step_move_gate
//   Gates a free-running step strobe so that exactly one move's worth of
//   steps reaches the phase sequencer. A rising edge on start_key latches
//   the move size and direction. Steps are then passed until the target
//   count is reached or the move is aborted.
//
// Parameters
//   STEPS_QTR  full-step count for a quarter turn (>= 1)
//   CNT_W      step-counter width, 2^CNT_W > 8*STEPS_QTR
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   step_in    one-cycle step strobe from the rate generator
//   start_key  move request level; its rising edge starts a move
//   turn_sel   move size: 0 quarter, 1 half, 2 three-quarter, 3 full turn
//   half_step  1 doubles the step count (half-step drive)
//   dir_in     requested direction, sampled in the start cycle only
//   abort      abort of the move in progress
//   step_out   gated step strobe (combinational)
//   dir_out    direction of the current/last move
//   busy       high while a move is running
//   done       one-cycle pulse on normal completion
//   aborted    one-cycle pulse after an abort
//   steps_done steps issued in the current/last move
module step_move_gate #(
  parameter int STEPS_QTR = 50,
  parameter int CNT_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_in,
  input  logic             start_key,
  input  logic [1:0]       turn_sel,
  input  logic             half_step,
  input  logic             dir_in,
  input  logic             abort,
  output logic             step_out,
  output logic             dir_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             start_prev;
  logic             start_edge;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] target_calc;
  logic [CNT_W-1:0] quarter_mult;

  // Rising edge of the move request, against last cycle's key level.
  assign start_edge = start_key & ~start_prev;

  // Step count of the requested move, quarters times the half-step factor.
  always_comb begin
    quarter_mult = CNT_W'(STEPS_QTR) * CNT_W'({1'b0, turn_sel} + 3'd1);
    if (half_step) begin
      target_calc = quarter_mult << 1;
    end else begin
      target_calc = quarter_mult;
    end
  end

  // Steps pass only while running; an abort strobe masks the coincident step.
  assign step_out = step_in & (state == RUN) & ~abort;

  // Move sequencing, step counting and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      start_prev <= 1'b0;
      target     <= '0;
      dir_out    <= 1'b0;
      steps_done <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      start_prev <= start_key;
      done       <= 1'b0;
      aborted    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state      <= RUN;
            target     <= target_calc;
            dir_out    <= dir_in;
            steps_done <= '0;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (step_in) begin
            steps_done <= steps_done + CNT_W'(1);
            // Last step of the move: leave RUN so the count cannot exceed target.
            if (steps_done == target - CNT_W'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_move_gate.sv
module tb_step_move_gate;

  localparam int STEPS_QTR = 2;
  localparam int CNT_W     = 12;

  logic             clk;
  logic             rst;
  logic             step_in;
  logic             start_key;
  logic [1:0]       turn_sel;
  logic             half_step;
  logic             dir_in;
  logic             abort;
  logic             step_out;
  logic             dir_out;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] steps_done;

  int checks   = 0;
  int failures = 0;

  // per-scenario observation counters, updated by cyc_run
  int pulses    = 0;
  int done_cnt  = 0;
  int abort_cnt = 0;
  int cyc       = 0;
  int done_cyc  = -1;

  step_move_gate #(.STEPS_QTR(STEPS_QTR), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .step_in    (step_in),
    .start_key  (start_key),
    .turn_sel   (turn_sel),
    .half_step  (half_step),
    .dir_in     (dir_in),
    .abort      (abort),
    .step_out   (step_out),
    .dir_out    (dir_out),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .steps_done (steps_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_obs();
    pulses    = 0;
    done_cnt  = 0;
    abort_cnt = 0;
    cyc       = 0;
    done_cyc  = -1;
  endtask

  // One clock cycle: apply inputs, observe at the falling edge, advance past the rising edge.
  task automatic cyc_run(input logic si, input logic ab);
    step_in = si;
    abort   = ab;
    @(negedge clk);
    cyc = cyc + 1;
    if (step_out) pulses = pulses + 1;
    if (aborted) abort_cnt = abort_cnt + 1;
    if (done) begin
      done_cnt = done_cnt + 1;
      if (done_cyc < 0) done_cyc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic si);
    start_key = 1'b1;
    cyc_run(si, 1'b0);
    start_key = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step_in = 1'b1; start_key = 1'b0; turn_sel = 2'd0;
    half_step = 1'b0; dir_in = 1'b1; abort = 1'b0;
    #23;
    checks = checks + 1;
    if (step_out !== 1'b0) begin failures = failures + 1; $display("FAIL reset_step_out: got %b expected 0", step_out); end
    checks = checks + 1;
    if ({busy, done, aborted, dir_out} !== 4'b0000) begin
      failures = failures + 1;
      $display("FAIL reset_flags: got busy/done/aborted/dir=%b expected 0000", {busy, done, aborted, dir_out});
    end
    checks = checks + 1;
    if (steps_done !== 12'd0) begin failures = failures + 1; $display("FAIL reset_steps: got %0d expected 0", steps_done); end
    @(posedge clk); #1;
    rst = 1'b1;
    step_in = 1'b0; dir_in = 1'b0;
    cyc_run(1'b0, 1'b0);
  endtask

  task automatic test_quarter();
    turn_sel = 2'd0; half_step = 1'b0; dir_in = 1'b0;
    press(1'b0);
    checks = checks + 1;
    if (busy !== 1'b1) begin failures = failures + 1; $display("FAIL quarter_busy: got %b expected 1", busy); end
    clear_obs();
    for (int i = 0; i < 5; i++) cyc_run(1'b1, 1'b0);
    checks = checks + 1;
    if (pulses != 2) begin failures = failures + 1; $display("FAIL quarter_pulses: got %0d expected 2", pulses); end
    checks = checks + 1;
    if (done_cnt != 1 || done_cyc != 3) begin
      failures = failures + 1;
      $display("FAIL quarter_done: got count %0d at cycle %0d expected 1 at 3", done_cnt, done_cyc);
    end
    checks = checks + 1;
    if (steps_done !== 12'd2 || busy !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL quarter_end: got steps %0d busy %b expected 2 0", steps_done, busy);
    end
  endtask

  task automatic test_half_full();
    int dir_bad  = 0;
    int busy_bad = 0;
    turn_sel = 2'd3; half_step = 1'b1; dir_in = 1'b1;
    press(1'b0);
    // changes after the start cycle must be ignored
    turn_sel = 2'd0; half_step = 1'b0; dir_in = 1'b0;
    clear_obs();
    for (int k = 1; k <= 20; k++) begin
      cyc_run(1'b1, 1'b0);
      if (dir_out !== 1'b1) dir_bad = dir_bad + 1;
      // busy sampled after the k-th rising edge: high through step 15, low from step 16 on
      if (busy !== ((k <= 15) ? 1'b1 : 1'b0)) busy_bad = busy_bad + 1;
    end
    checks = checks + 1;
    if (pulses != 16) begin failures = failures + 1; $display("FAIL full_pulses: got %0d expected 16", pulses); end
    checks = checks + 1;
    if (steps_done !== 12'd16) begin failures = failures + 1; $display("FAIL full_steps: got %0d expected 16", steps_done); end
    checks = checks + 1;
    if (done_cnt != 1 || done_cyc != 17) begin
      failures = failures + 1;
      $display("FAIL full_done: got count %0d at cycle %0d expected 1 at 17", done_cnt, done_cyc);
    end
    checks = checks + 1;
    if (dir_bad != 0) begin failures = failures + 1; $display("FAIL full_dir: got %0d bad cycles expected 0", dir_bad); end
    checks = checks + 1;
    if (busy_bad != 0) begin failures = failures + 1; $display("FAIL full_busy: got %0d bad cycles expected 0", busy_bad); end
  endtask

  task automatic test_held_key();
    turn_sel = 2'd0; half_step = 1'b0; dir_in = 1'b0;
    start_key = 1'b1;
    clear_obs();
    for (int i = 0; i < 6; i++) cyc_run(1'b1, 1'b0);
    checks = checks + 1;
    if (pulses != 2 || done_cnt != 1) begin
      failures = failures + 1;
      $display("FAIL held_first: got pulses %0d done %0d expected 2 1", pulses, done_cnt);
    end
    clear_obs();
    for (int i = 0; i < 6; i++) cyc_run(1'b1, 1'b0);
    checks = checks + 1;
    if (pulses != 0 || busy !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL held_retrigger: got pulses %0d busy %b expected 0 0", pulses, busy);
    end
    start_key = 1'b0;
    cyc_run(1'b0, 1'b0);
  endtask

  task automatic test_abort();
    turn_sel = 2'd1; half_step = 1'b0; dir_in = 1'b1;
    press(1'b0);
    clear_obs();
    cyc_run(1'b1, 1'b0);
    cyc_run(1'b1, 1'b0);
    cyc_run(1'b1, 1'b1);
    cyc_run(1'b0, 1'b0);
    cyc_run(1'b1, 1'b0);
    cyc_run(1'b1, 1'b0);
    cyc_run(1'b0, 1'b1);
    cyc_run(1'b0, 1'b0);
    checks = checks + 1;
    if (pulses != 2) begin failures = failures + 1; $display("FAIL abort_pulses: got %0d expected 2", pulses); end
    checks = checks + 1;
    if (abort_cnt != 1 || done_cnt != 0) begin
      failures = failures + 1;
      $display("FAIL abort_flags: got aborted %0d done %0d expected 1 0", abort_cnt, done_cnt);
    end
    checks = checks + 1;
    if (steps_done !== 12'd2 || busy !== 1'b0 || dir_out !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL abort_hold: got steps %0d busy %b dir %b expected 2 0 1", steps_done, busy, dir_out);
    end
  endtask

  task automatic test_reset_mid();
    turn_sel = 2'd0; half_step = 1'b0; dir_in = 1'b1;
    press(1'b0);
    cyc_run(1'b1, 1'b0);
    step_in = 1'b1;
    rst = 1'b0;
    #1;
    checks = checks + 1;
    if ({step_out, busy, done, aborted, dir_out} !== 5'b00000 || steps_done !== 12'd0) begin
      failures = failures + 1;
      $display("FAIL midreset_outputs: got out/busy/done/ab/dir=%b steps %0d expected 00000 0",
               {step_out, busy, done, aborted, dir_out}, steps_done);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    clear_obs();
    for (int i = 0; i < 4; i++) cyc_run(1'b1, 1'b0);
    checks = checks + 1;
    if (pulses != 0 || done_cnt != 0 || abort_cnt != 0) begin
      failures = failures + 1;
      $display("FAIL midreset_idle: got pulses %0d done %0d aborted %0d expected 0 0 0", pulses, done_cnt, abort_cnt);
    end
    press(1'b0);
    clear_obs();
    for (int i = 0; i < 3; i++) cyc_run(1'b1, 1'b0);
    checks = checks + 1;
    if (pulses != 2 || done_cnt != 1) begin
      failures = failures + 1;
      $display("FAIL midreset_restart: got pulses %0d done %0d expected 2 1", pulses, done_cnt);
    end
  endtask

  task automatic test_coincident();
    turn_sel = 2'd0; half_step = 1'b0; dir_in = 1'b0;
    clear_obs();
    press(1'b1);
    checks = checks + 1;
    if (pulses != 0) begin failures = failures + 1; $display("FAIL coincident_first: got %0d expected 0", pulses); end
    for (int i = 0; i < 4; i++) cyc_run(1'b1, 1'b0);
    checks = checks + 1;
    if (pulses != 2 || done_cnt != 1 || steps_done !== 12'd2) begin
      failures = failures + 1;
      $display("FAIL coincident_move: got pulses %0d done %0d steps %0d expected 2 1 2", pulses, done_cnt, steps_done);
    end
  endtask

  initial begin
    test_reset();
    test_quarter();
    test_half_full();
    test_held_key();
    test_abort();
    test_reset_mid();
    test_coincident();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_move_gate.md
STEP_MOVE_GATE -- requirements
Module: step_move_gate

Interface
REQ-001 Parameter STEPS_QTR, default 50, full-step count for one quarter turn; SHALL be >= 1.
REQ-002 Parameter CNT_W, default 12, step-counter width; SHALL satisfy 2^CNT_W > 8*STEPS_QTR.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 step_in  input  1  step strobe from step-rate generator; one clk cycle high per step.
REQ-006 start_key  input  1  move request, level, synchronous to clk; rising edge starts a move.
REQ-007 turn_sel  input  2  move size: 0 quarter, 1 half, 2 three-quarter, 3 full turn.
REQ-008 half_step  input  1  1 = half-step mode (double step count), 0 = full-step mode.
REQ-009 dir_in  input  1  requested direction.
REQ-010 abort  input  1  synchronous abort of the move in progress.
REQ-011 step_out  output  1  gated step strobe to the phase sequencer.
REQ-012 dir_out  output  1  direction latched for the current/last move.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 aborted  output  1  one-cycle pulse when a move is aborted.
REQ-016 steps_done  output  CNT_W  steps issued in the current/last move.

Function
REQ-017 Start edge SHALL be detected as start_key=1 with previous-cycle start_key=0, using a register updated every cycle in all states.
REQ-018 FSM states SHALL be IDLE, RUN, DONE.
REQ-019 IDLE: on start edge -> RUN; latch target = STEPS_QTR*(turn_sel+1)*(half_step?2:1), computed in CNT_W bits; latch dir_out = dir_in; clear steps_done.
REQ-020 turn_sel, half_step, dir_in SHALL be ignored except in the start cycle; changes during RUN have no effect.
REQ-021 RUN: each cycle with step_in=1 and abort=0 SHALL increment steps_done by 1.
REQ-022 RUN: when step_in=1, abort=0 and steps_done == target-1 -> DONE next cycle (steps_done reaches target).
REQ-023 RUN: abort=1 -> IDLE next cycle, aborted=1 that cycle, steps_done holds its value, no done pulse.
REQ-024 DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-025 Start edges in RUN or DONE SHALL be ignored, not queued; a key held high SHALL NOT retrigger.
REQ-026 abort in IDLE or DONE SHALL have no effect.
REQ-027 step_out SHALL be combinational: step_in AND (state==RUN) AND NOT abort; exactly target pulses per completed move.
REQ-028 busy SHALL be registered state decode (state==RUN); high from the cycle after the start edge.
REQ-029 Latency: first step_in accepted in the cycle after the start edge; step_in coincident with the start edge SHALL NOT be passed.
REQ-030 Counter SHALL never wrap; steps_done <= target by construction.
REQ-031 dir_out and steps_done SHALL hold after DONE/abort until the next accepted start.

Reset
REQ-032 rst=0 SHALL force within the same cycle: state IDLE, steps_done 0, dir_out 0, busy 0, done 0, aborted 0, start-edge register 0, target 0; step_out 0.
REQ-033 rst asserted mid-move SHALL discard the move with no done/aborted pulse; after release a fresh start edge is required.

Verification (bench with STEPS_QTR=2)
REQ-034 half_step=0, turn_sel=0, start edge, 5 step_in strobes -> exactly 2 step_out pulses, done pulse one cycle after 2nd, steps_done=2.
REQ-035 half_step=1, turn_sel=3, dir_in=1 -> 16 step_out pulses, dir_out=1 throughout, busy high until done, steps_done=16.
REQ-036 start_key held high across completion, then further step_in -> no second move, step_out stays 0.
REQ-037 turn_sel=1 full-step, abort coincident with 3rd step_in -> 2 step_out pulses, aborted pulse, no done, steps_done=2.
REQ-038 rst pulsed low after 1 step of a quarter move -> all outputs 0 immediately; subsequent step_in gives no step_out until a new start edge.
REQ-039 step_in=1 in the start-edge cycle, turn_sel=0 full-step -> that strobe not passed; next 2 strobes pass, then done.
